// File: rtl/planificador_nonces_if.sv
// Bus between the nonce scheduler and the parallel hash-core array.
// One start/nonce pair per lane goes out, one done/hash pair per lane comes back.
interface planificador_nonces_if #(
   parameter int N = 4
);
   logic [N-1:0]    core_start;
   logic [32*N-1:0] core_nonce;
   logic [N-1:0]    core_done;
   logic [24*N-1:0] core_hash;

   modport master (
      output core_start,
      output core_nonce,
      input  core_done,
      input  core_hash
   );

   modport slave (
      input  core_start,
      input  core_nonce,
      output core_done,
      output core_hash
   );
endinterface

// File: rtl/planificador_nonces.sv
// Nonce search scheduler: hands a distinct nonce to each hash core per batch,
// waits for every active lane, then compares the hashes against the target.
// The search stops on the first hit (lowest lane wins), on nonce exhaustion,
// or when a batch does not complete within TIMEOUT_CICLOS cycles.
module planificador_nonces #(
   parameter int          NUM_BLOQUES_PARALELOS = 4,
   parameter logic [31:0] NONCE_MAX             = 32'hFFFFFFFF,
   parameter int          TIMEOUT_CICLOS        = 1024
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 inicio,
   input  logic [7:0]           target,
   input  logic [31:0]          nonce_base,
   planificador_nonces_if.master cores,
   output logic [31:0]          nonce_out,
   output logic [23:0]          hash_out,
   output logic                 terminado,
   output logic                 agotado,
   output logic                 error,
   output logic                 ocupado
);

   localparam int              N      = NUM_BLOQUES_PARALELOS;
   localparam int              CW     = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [32:0]     MAX33  = {1'b0, NONCE_MAX};
   localparam logic [CW-1:0]   T_LAST = CW'(TIMEOUT_CICLOS - 1);

   typedef enum logic [2:0] {IDLE, DESPACHO, ESPERA, EVALUA, FIN} estado_t;

   estado_t       estado, estado_sig;
   logic [32:0]   next_nonce;
   logic [7:0]    target_q;
   logic [N-1:0]  lane_activa;
   logic [N-1:0]  hecho_mask;
   logic [N-1:0]  hecho_sig;
   logic [N-1:0]  activa_comb;
   logic [23:0]   hash_q [N];
   logic [CW-1:0] cnt;
   logic          hay_hit;
   logic [31:0]   nonce_gan;
   logic [23:0]   hash_gan;

   // A lane is done once it has reported or if it was never started.
   assign hecho_sig = hecho_mask | cores.core_done;
   assign ocupado   = (estado == DESPACHO) || (estado == ESPERA) || (estado == EVALUA);

   // Lanes whose nonce still fits below NONCE_MAX for the batch about to go out.
   always_comb begin
      activa_comb = '0;
      for (int i = 0; i < N; i++) begin
         activa_comb[i] = (next_nonce + 33'(i)) <= MAX33;
      end
   end

   // Hit detection; scanning downwards leaves the lowest hitting lane as winner.
   always_comb begin
      hay_hit   = 1'b0;
      nonce_gan = '0;
      hash_gan  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (lane_activa[i] && (hash_q[i][23:16] < target_q) && (hash_q[i][15:8] < target_q)) begin
            hay_hit   = 1'b1;
            nonce_gan = cores.core_nonce[32*i +: 32];
            hash_gan  = hash_q[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) estado <= IDLE;
      else          estado <= estado_sig;
   end

   // Next-state logic; dropping inicio mid-search always returns to IDLE.
   always_comb begin
      estado_sig = estado;
      case (estado)
         IDLE:     if (inicio) estado_sig = DESPACHO;
         DESPACHO: estado_sig = inicio ? ESPERA : IDLE;
         ESPERA: begin
            if (!inicio)          estado_sig = IDLE;
            else if (&hecho_sig)  estado_sig = EVALUA;
            else if (cnt == T_LAST) estado_sig = FIN;
         end
         EVALUA: begin
            if (!inicio)                         estado_sig = IDLE;
            else if (hay_hit || next_nonce > MAX33) estado_sig = FIN;
            else                                 estado_sig = DESPACHO;
         end
         FIN:      if (!inicio) estado_sig = IDLE;
         default:  estado_sig = IDLE;
      endcase
   end

   // Datapath: nonce issue, done collection, timeout counting and result capture.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         cores.core_start <= '0;
         cores.core_nonce <= '0;
         next_nonce       <= '0;
         target_q         <= '0;
         lane_activa      <= '0;
         hecho_mask       <= '0;
         cnt              <= '0;
         nonce_out        <= '0;
         hash_out         <= '0;
         terminado        <= 1'b0;
         agotado          <= 1'b0;
         error            <= 1'b0;
         for (int i = 0; i < N; i++) hash_q[i] <= '0;
      end else begin
         cores.core_start <= '0;
         case (estado)
            IDLE: begin
               if (inicio) begin
                  target_q   <= target;
                  next_nonce <= {1'b0, nonce_base};
                  terminado  <= 1'b0;
                  agotado    <= 1'b0;
                  error      <= 1'b0;
                  nonce_out  <= '0;
                  hash_out   <= '0;
               end
            end
            DESPACHO: begin
               if (inicio) begin
                  for (int i = 0; i < N; i++) begin
                     cores.core_nonce[32*i +: 32] <= activa_comb[i] ? 32'(next_nonce + 33'(i)) : 32'd0;
                  end
                  cores.core_start <= activa_comb;
                  lane_activa      <= activa_comb;
                  hecho_mask       <= ~activa_comb;
                  next_nonce       <= next_nonce + 33'(N);
                  cnt              <= '0;
               end
            end
            ESPERA: begin
               if (inicio) begin
                  for (int i = 0; i < N; i++) begin
                     if (cores.core_done[i] && !hecho_mask[i]) hash_q[i] <= cores.core_hash[24*i +: 24];
                  end
                  hecho_mask <= hecho_sig;
                  cnt        <= cnt + CW'(1);
                  if (!(&hecho_sig) && cnt == T_LAST) error <= 1'b1;
               end
            end
            EVALUA: begin
               if (inicio) begin
                  if (hay_hit) begin
                     nonce_out <= nonce_gan;
                     hash_out  <= hash_gan;
                     terminado <= 1'b1;
                  end else if (next_nonce > MAX33) begin
                     agotado <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_planificador_nonces.sv
// Bench for planificador_nonces: two instances share stimulus, one with the full
// nonce space and one with NONCE_MAX=10; behavioural mock cores answer each start.
module tb_planificador_nonces;

   localparam int N = 4;

   logic        clk;
   logic        reset_L;
   logic        inicio;
   logic [7:0]  target;
   logic [31:0] nonce_base;

   logic [N-1:0]    start_o     [2];
   logic [32*N-1:0] nonce_bus_o [2];
   logic [N-1:0]    done_o      [2];
   logic [31:0]     nonce_out_o [2];
   logic [23:0]     hash_out_o  [2];
   logic            term_o      [2];
   logic            agot_o      [2];
   logic            err_o       [2];
   logic            ocup_o      [2];

   int          lat   [N];
   logic [31:0] hit_n [2];
   logic [23:0] hit_h [2];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      string       name;
      int          dut;
      logic [31:0] base;
      logic [7:0]  tgt;
      logic [31:0] hn0;
      logic [23:0] hh0;
      logic [31:0] hn1;
      logic [23:0] hh1;
      logic [31:0] exp_nonce;
      logic [23:0] exp_hash;
      logic        exp_term;
      logic        exp_agot;
   } vec_t;

   vec_t vecs [7];

   // Mock hash: every nonce misses unless listed in the hit table.
   function automatic logic [23:0] hash_de(input logic [31:0] n);
      logic [23:0] h;
      h = 24'hFFFFFF;
      for (int j = 0; j < 2; j++) if (hit_n[j] == n) h = hit_h[j];
      return h;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle index used to measure latencies.
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam logic [31:0] NMAX = (k == 0) ? 32'hFFFFFFFF : 32'd10;

      planificador_nonces_if #(.N(N)) bus ();

      planificador_nonces #(
         .NUM_BLOQUES_PARALELOS(N),
         .NONCE_MAX(NMAX),
         .TIMEOUT_CICLOS(16)
      ) dut (
         .clk(clk),
         .reset_L(reset_L),
         .inicio(inicio),
         .target(target),
         .nonce_base(nonce_base),
         .cores(bus.master),
         .nonce_out(nonce_out_o[k]),
         .hash_out(hash_out_o[k]),
         .terminado(term_o[k]),
         .agotado(agot_o[k]),
         .error(err_o[k]),
         .ocupado(ocup_o[k])
      );

      assign start_o[k]     = bus.core_start;
      assign nonce_bus_o[k] = bus.core_nonce;
      assign done_o[k]      = bus.core_done;

      int          cnt_m   [N];
      logic [31:0] nonce_m [N];

      // Mock cores: a lane answers lat[i] cycles after its start; lat 0 never answers.
      always @(posedge clk or negedge reset_L) begin
         if (!reset_L) begin
            bus.core_done <= '0;
            bus.core_hash <= '0;
            for (int i = 0; i < N; i++) begin
               cnt_m[i]   <= 0;
               nonce_m[i] <= '0;
            end
         end else begin
            for (int i = 0; i < N; i++) begin
               bus.core_done[i] <= 1'b0;
               if (bus.core_start[i]) begin
                  nonce_m[i] <= bus.core_nonce[32*i +: 32];
                  cnt_m[i]   <= lat[i];
               end else if (cnt_m[i] == 1) begin
                  bus.core_done[i]         <= 1'b1;
                  bus.core_hash[24*i +: 24] <= hash_de(nonce_m[i]);
                  cnt_m[i]                 <= 0;
               end else if (cnt_m[i] > 1) begin
                  cnt_m[i] <= cnt_m[i] - 1;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic clearMock();
      for (int i = 0; i < N; i++) lat[i] = 5;
      for (int j = 0; j < 2; j++) begin
         hit_n[j] = 32'hFFFFFFFF;
         hit_h[j] = 24'hFFFFFF;
      end
   endtask

   task automatic pulseReset();
      inicio  = 1'b0;
      reset_L = 1'b0;
      clearMock();
      repeat (2) @(posedge clk);
      #1 reset_L = 1'b1;
   endtask

   task automatic waitResult(input int d, input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (term_o[d] || agot_o[d] || err_o[d]) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s_wait: got no result, expected one within 400 cycles", name);
      end
   endtask

   task automatic waitStart(input int d, input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (start_o[d] != '0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s_start: got no core_start, expected one within 50 cycles", name);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      pulseReset();
      hit_n[0]   = v.hn0;
      hit_h[0]   = v.hh0;
      hit_n[1]   = v.hn1;
      hit_h[1]   = v.hh1;
      target     = v.tgt;
      nonce_base = v.base;
      @(posedge clk);
      #1 inicio = 1'b1;
      waitResult(v.dut, v.name);
   endtask

   initial begin
      int s, last_done, restart_gap, term_gap, starts;
      logic [N-1:0] last_vec;

      vecs[0] = '{"basic_hit",  0, 32'd0,  8'h0a, 32'd6,  24'h0005FF, 32'hFFFFFFFF, 24'hFFFFFF, 32'd6,  24'h0005FF, 1'b1, 1'b0};
      vecs[1] = '{"tie",        0, 32'd8,  8'h0a, 32'd10, 24'h010203, 32'd9,        24'h090909, 32'd9,  24'h090909, 1'b1, 1'b0};
      vecs[2] = '{"equal_byte", 0, 32'd8,  8'h0a, 32'd9,  24'h0A0000, 32'd10,       24'h00090F, 32'd10, 24'h00090F, 1'b1, 1'b0};
      vecs[3] = '{"mid_byte",   0, 32'd12, 8'h0a, 32'd12, 24'h000B00, 32'd13,       24'h010000, 32'd13, 24'h010000, 1'b1, 1'b0};
      vecs[4] = '{"exhaust",    1, 32'd8,  8'h0a, 32'hFFFFFFFF, 24'hFFFFFF, 32'hFFFFFFFF, 24'hFFFFFF, 32'd0, 24'h0, 1'b0, 1'b1};
      vecs[5] = '{"hit_last",   1, 32'd8,  8'h0a, 32'd10, 24'h000000, 32'hFFFFFFFF, 24'hFFFFFF, 32'd10, 24'h000000, 1'b1, 1'b0};
      vecs[6] = '{"target_0",   1, 32'd8,  8'h00, 32'd9,  24'h000000, 32'hFFFFFFFF, 24'hFFFFFF, 32'd0,  24'h0, 1'b0, 1'b1};

      clearMock();
      inicio     = 1'b0;
      target     = 8'h00;
      nonce_base = 32'd0;
      reset_L    = 1'b0;
      @(negedge clk);
      checkOutput("rst_ocupado",   ocup_o[0],      0);
      checkOutput("rst_terminado", term_o[0],      0);
      checkOutput("rst_agotado",   agot_o[0],      0);
      checkOutput("rst_error",     err_o[0],       0);
      checkOutput("rst_nonce_out", nonce_out_o[0], 0);
      checkOutput("rst_hash_out",  hash_out_o[0],  0);
      checkOutput("rst_start",     start_o[0],     0);
      checkOutput("rst_core_nonce", nonce_bus_o[0], 0);
      @(posedge clk);
      #1 reset_L = 1'b1;

      // Table-driven searches.
      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v]);
         checkOutput({vecs[v].name, "_nonce_out"}, nonce_out_o[vecs[v].dut], vecs[v].exp_nonce);
         checkOutput({vecs[v].name, "_hash_out"},  hash_out_o[vecs[v].dut],  vecs[v].exp_hash);
         checkOutput({vecs[v].name, "_terminado"}, term_o[vecs[v].dut],      vecs[v].exp_term);
         checkOutput({vecs[v].name, "_agotado"},   agot_o[vecs[v].dut],      vecs[v].exp_agot);
         checkOutput({vecs[v].name, "_error"},     err_o[vecs[v].dut],       0);
         checkOutput({vecs[v].name, "_ocupado"},   ocup_o[vecs[v].dut],      0);
         @(posedge clk);
         #1 inicio = 1'b0;
      end

      // Partial last batch: only the lanes at or below NONCE_MAX start.
      pulseReset();
      target     = 8'h0a;
      nonce_base = 32'd8;
      @(posedge clk);
      #1 inicio = 1'b1;
      waitStart(1, "partial");
      checkOutput("partial_core_start", start_o[1], 4'b0111);
      checkOutput("partial_core_nonce", nonce_bus_o[1], {32'd0, 32'd10, 32'd9, 32'd8});

      // Skewed done latencies: lane 1 answers last.
      pulseReset();
      lat[0] = 3; lat[1] = 7; lat[2] = 5; lat[3] = 4;
      hit_n[0]   = 32'd4;
      hit_h[0]   = 24'h000000;
      target     = 8'h0a;
      nonce_base = 32'd0;
      last_done = -100; restart_gap = -1; term_gap = -1; starts = 0; last_vec = '0;
      @(posedge clk);
      #1 inicio = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (done_o[0] != '0) begin
            last_done = cyc;
            last_vec  = done_o[0];
         end
         if (start_o[0] != '0) begin
            starts++;
            if (starts == 2) restart_gap = cyc - last_done;
         end
         if (term_o[0]) begin
            term_gap = cyc - last_done;
            break;
         end
      end
      checkOutput("skew_last_lane",   last_vec,    4'b0010);
      checkOutput("skew_restart_gap", restart_gap, 3);
      checkOutput("skew_term_gap",    term_gap,    2);
      checkOutput("skew_nonce_out",   nonce_out_o[0], 32'd4);

      // Timeout: lane 2 never answers.
      pulseReset();
      lat[2]     = 0;
      target     = 8'h0a;
      nonce_base = 32'd0;
      s = -1; term_gap = -1;
      @(posedge clk);
      #1 inicio = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (start_o[0] != '0 && s < 0) s = cyc;
         if (err_o[0]) begin
            term_gap = cyc - s;
            break;
         end
      end
      checkOutput("timeout_cycles",    term_gap,  16);
      checkOutput("timeout_error",     err_o[0],  1);
      checkOutput("timeout_terminado", term_o[0], 0);
      checkOutput("timeout_ocupado",   ocup_o[0], 0);

      // Abort during ESPERA, then a fresh search from nonce_base.
      pulseReset();
      target     = 8'h0a;
      nonce_base = 32'h20;
      @(posedge clk);
      #1 inicio = 1'b1;
      waitStart(0, "abort");
      @(posedge clk);
      #1 inicio = 1'b0;
      @(negedge clk);
      checkOutput("abort_still_busy", ocup_o[0], 1);
      @(negedge clk);
      checkOutput("abort_idle", ocup_o[0], 0);
      starts = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (start_o[0] != '0 || ocup_o[0]) starts++;
      end
      checkOutput("abort_quiet",     starts,         0);
      checkOutput("abort_terminado", term_o[0],      0);
      checkOutput("abort_nonce_out", nonce_out_o[0], 0);
      hit_n[0] = 32'h21;
      hit_h[0] = 24'h000000;
      @(posedge clk);
      #1 inicio = 1'b1;
      waitStart(0, "restart");
      checkOutput("restart_lane0_nonce", nonce_bus_o[0][31:0], 32'h20);
      waitResult(0, "restart");
      checkOutput("restart_nonce_out", nonce_out_o[0], 32'h21);
      checkOutput("restart_terminado", term_o[0],      1);

      // Asynchronous reset in the middle of ESPERA.
      pulseReset();
      target     = 8'h0a;
      nonce_base = 32'h100;
      @(posedge clk);
      #1 inicio = 1'b1;
      waitStart(0, "reset_mid");
      @(posedge clk);
      #1;
      checkOutput("reset_mid_busy", ocup_o[0], 1);
      reset_L = 1'b0;
      #1;
      checkOutput("reset_mid_ocupado",    ocup_o[0],      0);
      checkOutput("reset_mid_core_nonce", nonce_bus_o[0], 0);
      checkOutput("reset_mid_start",      start_o[0],     0);
      inicio = 1'b0;
      @(posedge clk);
      #1 reset_L = 1'b1;
      @(negedge clk);
      checkOutput("reset_rel_ocupado",   ocup_o[0], 0);
      checkOutput("reset_rel_terminado", term_o[0], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/planificador_nonces.md
Name: planificador_nonces

Overview:
- Controller that sequences NUM_BLOQUES_PARALELOS micro_ucr_hash cores during a nonce search.
- Each batch, it gives every core a distinct nonce and pulses its start. It then waits for all active cores to finish and checks their 24-bit hashes against the target.
- Stops on the first hit (lowest lane wins), on nonce-space exhaustion, or on a core timeout.
- Sits between the top-level search interface (inicio/target/terminado) and the parallel hash array.

Parameters:
- NUM_BLOQUES_PARALELOS, 4, number of hash cores driven; nonce stride per batch.
- NONCE_MAX, 32'hFFFFFFFF, highest nonce that may be issued.
- TIMEOUT_CICLOS, 1024, maximum cycles in ESPERA before aborting with error.

Ports:
- clk  input  1  single clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- inicio  input  1  search request, level; a search starts when inicio is high while in IDLE.
- target  input  8  threshold; latched at start.
- nonce_base  input  32  first nonce of the search; latched at start.
- core_start  output  N  one-cycle start pulse per lane.
- core_nonce  output  32*N  nonce for lane i on [32*i+:32]; held stable until the next DESPACHO.
- core_done  input  N  lane completion, pulse or level.
- core_hash  input  24*N  lane hash on [24*i+:24]; valid while core_done[i] is high.
- nonce_out  output  32  winning nonce.
- hash_out  output  24  winning hash.
- terminado  output  1  search ended with a hit.
- agotado  output  1  search ended without a hit (nonce space exhausted).
- error  output  1  ESPERA timeout.
- ocupado  output  1  high in every state except IDLE and FIN.

Behaviour:
- Reset (async, reset_L=0):
  - state=IDLE.
  - All outputs 0: core_start, core_nonce, nonce_out, hash_out, terminado, agotado, error, ocupado.
  - Internal masks, counters and latches cleared.
- Nonce arithmetic:
  - next_nonce is a 33-bit register.
  - Lane i of a batch is active iff next_nonce+i <= NONCE_MAX.
  - Inactive lanes: core_start[i]=0, core_nonce[i] is driven 0, and the lane counts as done immediately.
- IDLE:
  - If inicio=1: latch target and nonce_base (next_nonce={1'b0,nonce_base}).
  - Clear terminado/agotado/error/nonce_out/hash_out.
  - Go to DESPACHO.
- DESPACHO (1 cycle):
  - core_nonce[i]<=next_nonce+i.
  - core_start[i]<=1 for active lanes; the pulse is visible during the following cycle only.
  - next_nonce<=next_nonce+N; hecho_mask<=~active_mask; timeout counter<=0.
  - Go to ESPERA.
- ESPERA:
  - Each cycle, for every i with core_done[i]=1 and hecho_mask[i]=0: latch core_hash[i] and set hecho_mask[i].
  - core_done during DESPACHO, EVALUA, FIN or IDLE is ignored.
  - When hecho_mask is all ones, go to EVALUA.
  - If the counter reaches TIMEOUT_CICLOS first: error<=1, go to FIN.
- EVALUA (1 cycle):
  - Lane i hits iff active, hash[23:16] < target and hash[15:8] < target (unsigned).
  - Lowest hitting index wins: nonce_out<=its nonce, hash_out<=its hash, terminado<=1, go to FIN.
  - Else, if next_nonce > NONCE_MAX: agotado<=1, go to FIN.
  - Else go to DESPACHO.
  - Latency: exactly 1 cycle from the last done to EVALUA, and 1 more cycle to the next DESPACHO.
- FIN:
  - Outputs held.
  - Returns to IDLE when inicio=0.
  - A new search therefore requires inicio to drop and rise again.
- Abort: inicio=0 in DESPACHO, ESPERA or EVALUA → IDLE next cycle.
  - Result outputs stay 0; the start pulse is not re-issued.
  - Late core_done pulses are ignored.
- target=0: no hit is possible; the search runs until agotado or error.
- Simultaneous events: a hit in EVALUA takes priority over exhaustion. Only one lane's result is ever reported.

Test Plan:
- Reset: hold reset_L=0 mid-ESPERA → all outputs 0 asynchronously, state IDLE; after release, ocupado=0.
- Basic hit: N=4, nonce_base=0, target=0x0a; mock cores (latency 5) return 0x0005FF only for nonce 6 → batches {0,1,2,3} then {4,5,6,7}; nonce_out=6, hash_out=0x0005FF, terminado=1, agotado=0.
- Tie: hits at nonces 9 and 10 in batch {8..11} → nonce_out=9; a hash 0x0A0000 (byte equal to target) is not a hit.
- Exhaustion: NONCE_MAX=10, nonce_base=8, no hits → core_start=4'b0111, core_nonce={0,10,9,8}; after one batch agotado=1, terminado=0.
- Skew and timeout: done latencies 3,7,5,4 → EVALUA exactly 1 cycle after the cycle-7 done. Separately, one lane never done with TIMEOUT_CICLOS=16 → error=1 after 16 ESPERA cycles.
- Abort and restart: drop inicio during ESPERA → IDLE next cycle, ocupado=0, subsequent core_done ignored; re-raise inicio → fresh search from nonce_base.
